// File: rtl/stream_packer_if.sv
// Stream bundle for stream_packer: narrow input side (s_*) and wide output
// side (m_*). The packer connects through the slave modport; the producer /
// consumer environment drives the master modport.
interface stream_packer_if #(
    parameter int DW_IN = 8,
    parameter int SCALE = 4
);
    logic [DW_IN-1:0]       s_data_i;
    logic                   s_last_i;
    logic                   s_valid_i;
    logic                   s_ready_o;
    logic [DW_IN*SCALE-1:0] m_data_o;
    logic [SCALE-1:0]       m_keep_o;
    logic                   m_last_o;
    logic                   m_valid_o;
    logic                   m_ready_i;

    // Packer view: consumes narrow beats, produces wide words.
    modport slave (
        input  s_data_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    // Environment view: produces narrow beats, consumes wide words.
    modport master (
        output s_data_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs SCALE narrow beats of DW_IN bits into one wide word.
// An input last closes the word early, producing a partial word described by
// the per-lane keep mask, and is forwarded as the output last.
// Two stages: an assembly register (lanes, beat index, keep mask) and an
// output register (data, keep, last, full flag).
// Optional build macro STREAM_PACKER_ZERO_PAD_EN: when defined, lanes whose
// keep bit is 0 are driven as zero; otherwise they carry stale contents.
module stream_packer #(
    parameter int DW_IN      = 8,
    parameter int SCALE      = 4,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst,
    stream_packer_if.slave    bus
);
    localparam int                 IDX_W    = (SCALE > 2) ? $clog2(SCALE) : 1;
    localparam int                 WW       = DW_IN * SCALE;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(SCALE - 1);

    // Assembly stage
    logic [DW_IN-1:0] lane_reg [SCALE];
    logic [IDX_W-1:0] idx_reg;
    logic [SCALE-1:0] akeep_reg;

    // Output stage
    logic [WW-1:0]    out_data_reg;
    logic [SCALE-1:0] out_keep_reg;
    logic             out_last_reg;
    logic             full_reg;

    // Registered copy of reset, holds ready low one extra cycle after reset
    logic             rst_r_reg;

    logic             s_ready;
    logic             wr;
    logic             rd;
    logic             complete;
    logic [IDX_W-1:0] lane_sel;
    logic [SCALE-1:0] lane_hit;
    logic [WW-1:0]    word_next;
    logic [SCALE-1:0] keep_next;

    // Ready depends only on the output stage and the consumer, never on s_*.
    assign s_ready  = !rst_r_reg && (!full_reg || bus.m_ready_i);
    assign wr       = bus.s_valid_i && s_ready;
    assign rd       = full_reg && bus.m_ready_i;
    assign complete = wr && ((idx_reg == IDX_LAST) || bus.s_last_i);

    // Lane addressed by the current beat: first beat in lane 0 or lane SCALE-1.
    assign lane_sel = (BIG_ENDIAN != 0) ? (IDX_LAST - idx_reg) : idx_reg;

    generate
        for (genvar gi = 0; gi < SCALE; gi++) begin : g_lane
            assign lane_hit[gi] = wr && (lane_sel == IDX_W'(gi));

            // The completing beat bypasses the lane register so the whole word
            // (including that beat) loads the output stage on the same edge.
            assign word_next[gi*DW_IN +: DW_IN] = lane_hit[gi] ? bus.s_data_i : lane_reg[gi];
            assign keep_next[gi]                = akeep_reg[gi] | lane_hit[gi];

`ifdef STREAM_PACKER_ZERO_PAD_EN
            // Lane storage, cleared whenever a word leaves so unused lanes read zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (complete) begin
                    lane_reg[gi] <= '0;
                end else if (lane_hit[gi]) begin
                    lane_reg[gi] <= bus.s_data_i;
                end
            end
`else
            // Lane storage; unused lanes keep stale data and are masked by keep.
            always_ff @(posedge clk) begin
                if (lane_hit[gi]) begin
                    lane_reg[gi] <= bus.s_data_i;
                end
            end
`endif
        end
    endgenerate

    // Reset shadow used to gate ready for the cycle following reset.
    always_ff @(posedge clk) begin
        rst_r_reg <= rst;
    end

    // Beat index, assembly keep mask and output register with full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg      <= '0;
            akeep_reg    <= '0;
            out_data_reg <= '0;
            out_keep_reg <= '0;
            out_last_reg <= 1'b0;
            full_reg     <= 1'b0;
        end else if (complete) begin
            // A completing write wins over a same-cycle read: new word replaces
            // the one being taken, so full stays set.
            idx_reg      <= '0;
            akeep_reg    <= '0;
            out_data_reg <= word_next;
            out_keep_reg <= keep_next;
            out_last_reg <= bus.s_last_i;
            full_reg     <= 1'b1;
        end else begin
            if (wr) begin
                idx_reg   <= idx_reg + IDX_W'(1);
                akeep_reg <= keep_next;
            end
            if (rd) begin
                full_reg <= 1'b0;
            end
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = out_data_reg;
    assign bus.m_keep_o  = out_keep_reg;
    assign bus.m_last_o  = out_last_reg;
    assign bus.m_valid_o = full_reg;

endmodule

// File: tb/tb_stream_packer.sv
// Testbench for stream_packer (DW_IN=8, SCALE=4): one little-endian and one
// big-endian instance, table-driven directed vectors plus a continuous-stream
// sequence with consumer back-pressure.
module tb_stream_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stream_packer_if #(.DW_IN(8), .SCALE(4)) bus_le ();
    stream_packer_if #(.DW_IN(8), .SCALE(4)) bus_be ();

    stream_packer #(.DW_IN(8), .SCALE(4), .BIG_ENDIAN(0)) dut_le (
        .clk (clk),
        .rst (rst),
        .bus (bus_le.slave)
    );

    stream_packer #(.DW_IN(8), .SCALE(4), .BIG_ENDIAN(1)) dut_be (
        .clk (clk),
        .rst (rst),
        .bus (bus_be.slave)
    );

    typedef struct {
        logic        rst;
        logic        be;
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        mready;
        logic        chk_rdy;
        logic        exp_rdy;
        logic        exp_mv;
        logic [3:0]  exp_keep;
        logic        exp_last;
        logic [31:0] exp_data;
        logic        chk_raw;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int l = 0; l < 4; l++) begin
            if (k[l]) m[l*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    function automatic vec_t mk(input logic r, input logic be, input logic v, input logic [7:0] d,
                                input logic l, input logic mr, input logic cr, input logic er,
                                input logic emv, input logic [3:0] ek, input logic el,
                                input logic [31:0] ed, input logic raw);
        vec_t x;
        x.rst = r; x.be = be; x.valid = v; x.data = d; x.last = l; x.mready = mr;
        x.chk_rdy = cr; x.exp_rdy = er; x.exp_mv = emv; x.exp_keep = ek;
        x.exp_last = el; x.exp_data = ed; x.chk_raw = raw;
        return x;
    endfunction

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        zero_pad;
        logic        a_rdy, a_mv, a_last;
        logic [3:0]  a_keep;
        logic [31:0] a_data;
        logic [31:0] exp_words [3];
        int          sent, got, stall, cyc, bubbles;
        logic        held_v;
        logic [31:0] held;
        logic        s_wr, s_rd;
        logic [31:0] s_word;
        logic [3:0]  s_keep;
        logic        s_lastv;

        zero_pad = 1'b0;
`ifdef STREAM_PACKER_ZERO_PAD_EN
        zero_pad = 1'b1;
`endif

        // rst be  v  data   last mr  chk exprdy  mv keep  last data          raw
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 0,  0, 4'h0, 0, 32'h00000000, 1)); // 0 reset
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 0,  0, 4'h0, 0, 32'h00000000, 1)); // 1 reset
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0,  0, 4'h0, 0, 32'h00000000, 1)); // 2 cycle after reset
        vecs.push_back(mk(0, 0, 1, 8'h11, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 3
        vecs.push_back(mk(0, 0, 1, 8'h22, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 4
        vecs.push_back(mk(0, 0, 1, 8'h33, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 5
        vecs.push_back(mk(0, 0, 1, 8'h44, 1, 1, 1, 1,  1, 4'hF, 1, 32'h44332211, 0)); // 6 full word + last
        vecs.push_back(mk(0, 0, 1, 8'hAA, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 7
        vecs.push_back(mk(0, 0, 1, 8'hBB, 1, 1, 1, 1,  1, 4'h3, 1, 32'h0000BBAA, 0)); // 8 partial
        vecs.push_back(mk(0, 0, 1, 8'h5A, 1, 1, 1, 1,  1, 4'h1, 1, 32'h0000005A, 0)); // 9 single beat, restarts lane 0
        vecs.push_back(mk(0, 0, 1, 8'h01, 0, 0, 1, 0,  1, 4'h1, 1, 32'h0000005A, 0)); // 10 held
        vecs.push_back(mk(0, 0, 1, 8'h01, 0, 0, 1, 0,  1, 4'h1, 1, 32'h0000005A, 0)); // 11 held
        vecs.push_back(mk(0, 0, 1, 8'h01, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 12 drain + beat
        vecs.push_back(mk(0, 0, 1, 8'h02, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 13
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1, 1,  0, 4'h0, 0, 32'h00000000, 1)); // 14 reset mid-word
        vecs.push_back(mk(0, 0, 1, 8'h10, 0, 1, 1, 0,  0, 4'h0, 0, 32'h00000000, 1)); // 15 extra not-ready cycle
        vecs.push_back(mk(0, 0, 1, 8'h10, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 16
        vecs.push_back(mk(0, 0, 1, 8'h20, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 17
        vecs.push_back(mk(0, 0, 1, 8'h30, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 18
        vecs.push_back(mk(0, 0, 1, 8'h40, 0, 1, 1, 1,  1, 4'hF, 0, 32'h40302010, 0)); // 19 clean word, no last
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 20
        vecs.push_back(mk(0, 1, 1, 8'h11, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 21 big-endian
        vecs.push_back(mk(0, 1, 1, 8'h22, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 22
        vecs.push_back(mk(0, 1, 1, 8'h33, 1, 1, 1, 1,  1, 4'hE, 1, 32'h11223300, 0)); // 23
        vecs.push_back(mk(0, 1, 1, 8'h44, 1, 1, 1, 1,  1, 4'h8, 1, 32'h44000000, 0)); // 24 single beat, lane 3
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 1,  0, 4'h0, 0, 32'h0,        0)); // 25

        bus_le.s_valid_i = 1'b0; bus_le.s_data_i = '0; bus_le.s_last_i = 1'b0; bus_le.m_ready_i = 1'b1;
        bus_be.s_valid_i = 1'b0; bus_be.s_data_i = '0; bus_be.s_last_i = 1'b0; bus_be.m_ready_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            if (vecs[i].be) begin
                bus_be.s_valid_i = vecs[i].valid; bus_be.s_data_i = vecs[i].data;
                bus_be.s_last_i = vecs[i].last;   bus_be.m_ready_i = vecs[i].mready;
                bus_le.s_valid_i = 1'b0; bus_le.s_last_i = 1'b0; bus_le.m_ready_i = 1'b1;
            end else begin
                bus_le.s_valid_i = vecs[i].valid; bus_le.s_data_i = vecs[i].data;
                bus_le.s_last_i = vecs[i].last;   bus_le.m_ready_i = vecs[i].mready;
                bus_be.s_valid_i = 1'b0; bus_be.s_last_i = 1'b0; bus_be.m_ready_i = 1'b1;
            end
            #1;
            a_rdy = vecs[i].be ? bus_be.s_ready_o : bus_le.s_ready_o;
            if (vecs[i].chk_rdy) chk($sformatf("vec%0d_s_ready", i), 64'(a_rdy), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            a_mv   = vecs[i].be ? bus_be.m_valid_o : bus_le.m_valid_o;
            a_keep = vecs[i].be ? bus_be.m_keep_o  : bus_le.m_keep_o;
            a_last = vecs[i].be ? bus_be.m_last_o  : bus_le.m_last_o;
            a_data = vecs[i].be ? bus_be.m_data_o  : bus_le.m_data_o;
            $display("vec %0d: rst=%0b be=%0b v=%0b d=%02h last=%0b mr=%0b -> m_valid=%0b keep=%04b last=%0b data=%08h",
                     i, vecs[i].rst, vecs[i].be, vecs[i].valid, vecs[i].data, vecs[i].last,
                     vecs[i].mready, a_mv, a_keep, a_last, a_data);
            chk($sformatf("vec%0d_m_valid", i), 64'(a_mv), 64'(vecs[i].exp_mv));
            if (vecs[i].exp_mv || vecs[i].chk_raw) begin
                chk($sformatf("vec%0d_m_keep", i), 64'(a_keep), 64'(vecs[i].exp_keep));
                chk($sformatf("vec%0d_m_last", i), 64'(a_last), 64'(vecs[i].exp_last));
                if (vecs[i].chk_raw || zero_pad)
                    chk($sformatf("vec%0d_m_data", i), 64'(a_data), 64'(vecs[i].exp_data));
                else
                    chk($sformatf("vec%0d_m_data_masked", i), 64'(a_data & lane_mask(vecs[i].exp_keep)),
                        64'(vecs[i].exp_data & lane_mask(vecs[i].exp_keep)));
            end
        end

        // Continuous 12-beat stream with a 5-cycle consumer stall after word 1.
        exp_words[0] = 32'h04030201;
        exp_words[1] = 32'h08070605;
        exp_words[2] = 32'h0C0B0A09;
        sent = 0; got = 0; stall = 0; cyc = 0; bubbles = 0; held_v = 1'b0; held = '0;
        bus_be.s_valid_i = 1'b0;
        while (got < 3 && cyc < 200) begin
            bus_le.m_ready_i = (stall == 0);
            bus_le.s_valid_i = (sent < 12);
            bus_le.s_data_i  = 8'(sent + 1);
            bus_le.s_last_i  = (sent == 11);
            #2;
            if (bus_le.m_valid_o && !bus_le.m_ready_i) begin
                chk("stream_stall_s_ready", 64'(bus_le.s_ready_o), 64'd0);
                if (held_v) chk("stream_stall_hold", 64'(bus_le.m_data_o), 64'(held));
                held   = bus_le.m_data_o;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (bus_le.s_valid_i && bus_le.m_ready_i && !bus_le.s_ready_o) bubbles++;
            s_wr    = bus_le.s_valid_i && bus_le.s_ready_o;
            s_rd    = bus_le.m_valid_o && bus_le.m_ready_i;
            s_word  = bus_le.m_data_o;
            s_keep  = bus_le.m_keep_o;
            s_lastv = bus_le.m_last_o;
            @(posedge clk);
            #1;
            cyc++;
            if (s_wr) sent++;
            if (s_rd) begin
                $display("stream word %0d: data=%08h keep=%04b last=%0b", got, s_word, s_keep, s_lastv);
                chk($sformatf("stream_word%0d_data", got), 64'(s_word), 64'(exp_words[got]));
                chk($sformatf("stream_word%0d_keep", got), 64'(s_keep), 64'hF);
                chk($sformatf("stream_word%0d_last", got), 64'(s_lastv), 64'(got == 2));
                got++;
                if (got == 1) stall = 5;
            end else if (stall > 0) begin
                stall--;
            end
        end
        bus_le.s_valid_i = 1'b0;
        bus_le.m_ready_i = 1'b1;
        chk("stream_words_out", 64'(got), 64'd3);
        chk("stream_beats_in", 64'(sent), 64'd12);
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        @(posedge clk);
        #1;
        chk("stream_drained", 64'(bus_le.m_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
